// File: rtl/branch_resolve_predict_pkg.sv
// Shared opcode constants, 2-bit counter encodings and the saturating
// counter step used by the branch predictor table.
package branch_pkg;

  localparam logic [5:0] OP_BLM = 6'd1;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;
  localparam logic [5:0] OP_BLE = 6'd6;
  localparam logic [5:0] OP_BGT = 6'd7;

  // Counter encodings: strong/weak not-taken, weak/strong taken.
  // The prediction is bit [1].
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Decoded view of a resolve request.
  typedef struct packed {
    logic is_branch;
    logic cond;
  } br_dec_t;

  // Move one step toward the observed outcome, clamping at both ends.
  function automatic logic [1:0] sat2_next(input logic [1:0] state,
                                           input logic       taken);
    logic [1:0] nxt;
    nxt = state;
    if (taken) begin
      if (state != ST) nxt = state + 2'd1;
    end else begin
      if (state != SNT) nxt = state - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_predict_if.sv
// Bus between the fetch/execute side and the branch resolver/predictor.
//
// Handshake: resolve_valid qualifies resolve_pc/opcode/flags for exactly the
// cycle it is high; there is no ready, the block accepts one resolve every
// cycle. taken_valid is a one-cycle pulse in the following cycle that
// qualifies taken and mispredict for a real branch opcode; when it is low,
// taken and mispredict are held at 0.
interface branch_resolve_predict_if #(
  parameter int STAT_W = 16
);
  logic [31:0]       lookup_pc;
  logic              predict_taken;
  logic              resolve_valid;
  logic [31:0]       resolve_pc;
  logic [5:0]        opcode;
  logic              igual;
  logic              maior;
  logic              menor;
  logic              taken;
  logic              taken_valid;
  logic              mispredict;
  logic [STAT_W-1:0] branch_count;
  logic [STAT_W-1:0] mispred_count;

  // Fetch/execute side drives requests and observes results.
  modport master (
    output lookup_pc, resolve_valid, resolve_pc, opcode, igual, maior, menor,
    input  predict_taken, taken, taken_valid, mispredict,
           branch_count, mispred_count
  );

  // The resolver/predictor itself.
  modport slave (
    input  lookup_pc, resolve_valid, resolve_pc, opcode, igual, maior, menor,
    output predict_taken, taken, taken_valid, mispredict,
           branch_count, mispred_count
  );
endinterface

// File: rtl/branch_resolve_predict_bht.sv
// Branch history table: 2^IDX_BITS two-bit saturating counters with one
// combinational lookup port and one read-modify-write update port.
module branch_bht
  import branch_pkg::*;
#(
  parameter int         IDX_BITS   = 4,
  parameter logic [1:0] INIT_STATE = WNT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_state,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken,
  output logic [1:0]          upd_state
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0] tbl [ENTRIES];

  // Both read ports see the table as it stands before the coming edge, so a
  // same-cycle lookup of an entry being updated returns the old value.
  always_comb begin
    rd_state  = tbl[rd_idx];
    upd_state = tbl[upd_idx];
  end

  // Reset loads every entry; otherwise step the addressed counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= INIT_STATE;
    end else if (upd_en) begin
      tbl[upd_idx] <= sat2_next(upd_state, upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_predict.sv
// Branch resolver with a bimodal predictor: decodes the branch condition
// from ALU flags, registers the outcome, trains the history table, flags
// mispredicts and keeps saturating statistics.
module branch_resolve_predict
  import branch_pkg::*;
#(
  parameter int         IDX_BITS   = 4,
  parameter int         STAT_W     = 16,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic                     clk,
  input  logic                     reset,
  branch_resolve_predict_if.slave  bus
);

  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  br_dec_t           dec;
  logic              do_update;
  logic [1:0]        lookup_state;
  logic [1:0]        resolve_state;
  logic              pred_old;
  logic              mispred_now;
  logic              taken_q;
  logic              taken_valid_q;
  logic              mispredict_q;
  logic [STAT_W-1:0] branch_count_q;
  logic [STAT_W-1:0] mispred_count_q;
  logic              pc_unused;

  // Only the word-aligned index bits address the table; the rest alias.
  assign pc_unused = ^{bus.lookup_pc[31:IDX_BITS+2], bus.lookup_pc[1:0],
                       bus.resolve_pc[31:IDX_BITS+2], bus.resolve_pc[1:0]};

  // Condition decode: unknown opcodes are not branches and never train.
  always_comb begin
    dec = '0;
    unique case (bus.opcode)
      OP_BEQ: dec = '{is_branch: 1'b1, cond: bus.igual};
      OP_BNE: dec = '{is_branch: 1'b1, cond: !bus.igual};
      OP_BLE: dec = '{is_branch: 1'b1, cond: !bus.maior};
      OP_BGT: dec = '{is_branch: 1'b1, cond: bus.maior};
      OP_BLM: dec = '{is_branch: 1'b1, cond: bus.menor};
      default: dec = '0;
    endcase
  end

  // A resolve counts only for a real branch; the prediction it is judged
  // against is the entry value before this edge.
  always_comb begin
    do_update   = bus.resolve_valid && dec.is_branch;
    pred_old    = resolve_state[1];
    mispred_now = dec.cond ^ pred_old;
  end

  branch_bht #(
    .IDX_BITS   (IDX_BITS),
    .INIT_STATE (INIT_STATE)
  ) u_bht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (bus.lookup_pc[IDX_BITS+1:2]),
    .rd_state  (lookup_state),
    .upd_en    (do_update),
    .upd_idx   (bus.resolve_pc[IDX_BITS+1:2]),
    .upd_taken (dec.cond),
    .upd_state (resolve_state)
  );

  // Outcome pulses last one cycle; statistics clamp at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q         <= 1'b0;
      taken_valid_q   <= 1'b0;
      mispredict_q    <= 1'b0;
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      taken_q       <= 1'b0;
      taken_valid_q <= 1'b0;
      mispredict_q  <= 1'b0;
      if (do_update) begin
        taken_q       <= dec.cond;
        taken_valid_q <= 1'b1;
        mispredict_q  <= mispred_now;
        if (branch_count_q != STAT_MAX)
          branch_count_q <= branch_count_q + 1'b1;
        if (mispred_now && (mispred_count_q != STAT_MAX))
          mispred_count_q <= mispred_count_q + 1'b1;
      end
    end
  end

  // Drive the bus from the registered state and the lookup port.
  always_comb begin
    bus.predict_taken = lookup_state[1];
    bus.taken         = taken_q;
    bus.taken_valid   = taken_valid_q;
    bus.mispredict    = mispredict_q;
    bus.branch_count  = branch_count_q;
    bus.mispred_count = mispred_count_q;
  end

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Scoreboard bench for branch_resolve_predict with a small table and
// narrow statistics so saturation is reachable.
module tb_branch_resolve_predict;

  localparam int IDX_BITS = 4;
  localparam int STAT_W   = 3;
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int STAT_MAX = (1 << STAT_W) - 1;
  localparam int REC_W    = 4 + 2 * STAT_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_predict_if #(.STAT_W(STAT_W)) bus ();

  branch_resolve_predict #(
    .IDX_BITS   (IDX_BITS),
    .STAT_W     (STAT_W),
    .INIT_STATE (2'b01)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  // Record layout: {predict_taken, taken, taken_valid, mispredict,
  //                 branch_count, mispred_count}
  logic [REC_W-1:0] exp_q[$];
  int   m_tbl [ENTRIES];
  logic m_taken, m_tv, m_mp;
  int   m_bc, m_mc;
  int   n_cmp;
  int   n_err;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic is_br(input logic [5:0] op);
    return (op == 6'd1) || (op >= 6'd4 && op <= 6'd7);
  endfunction

  function automatic logic cond_of(input logic [5:0] op, input logic eq,
                                   input logic gt, input logic lt);
    case (op)
      6'd4:    return eq;
      6'd5:    return !eq;
      6'd6:    return !gt;
      6'd7:    return gt;
      6'd1:    return lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 1;
    m_taken = 1'b0; m_tv = 1'b0; m_mp = 1'b0;
    m_bc = 0; m_mc = 0;
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: apply inputs, push the expectation for
  // this cycle, advance the model across the next edge, then wait for it.
  task automatic drive(input logic rst, input logic [31:0] lpc,
                       input logic rv, input logic [31:0] rpc,
                       input logic [5:0] op, input logic eq,
                       input logic gt, input logic lt);
    logic exp_pred;
    logic c, p;
    int   i;
    reset = rst;
    bus.lookup_pc = lpc; bus.resolve_valid = rv; bus.resolve_pc = rpc;
    bus.opcode = op; bus.igual = eq; bus.maior = gt; bus.menor = lt;
    exp_pred = (m_tbl[idx_of(lpc)] >= 2);
    exp_q.push_back({exp_pred, m_taken, m_tv, m_mp,
                     STAT_W'(m_bc), STAT_W'(m_mc)});
    if (rst) begin
      model_reset();
    end else if (rv && is_br(op)) begin
      i = idx_of(rpc);
      c = cond_of(op, eq, gt, lt);
      p = (m_tbl[i] >= 2);
      m_taken = c; m_tv = 1'b1; m_mp = (c != p);
      if (m_bc < STAT_MAX) m_bc++;
      if (m_mp && m_mc < STAT_MAX) m_mc++;
      if (c) m_tbl[i] = (m_tbl[i] < 3) ? m_tbl[i] + 1 : 3;
      else   m_tbl[i] = (m_tbl[i] > 0) ? m_tbl[i] - 1 : 0;
    end else begin
      m_taken = 1'b0; m_tv = 1'b0; m_mp = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] lpc);
    drive(1'b0, lpc, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic [31:0] lpc, input logic [31:0] rpc,
                         input logic [5:0] op, input logic eq,
                         input logic gt, input logic lt);
    drive(1'b0, lpc, 1'b1, rpc, op, eq, gt, lt);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [REC_W-1:0] r;
      r = exp_q.pop_front();
      check("predict_taken", int'(bus.predict_taken), int'(r[REC_W-1]));
      check("taken",         int'(bus.taken),         int'(r[REC_W-2]));
      check("taken_valid",   int'(bus.taken_valid),   int'(r[REC_W-3]));
      check("mispredict",    int'(bus.mispredict),    int'(r[REC_W-4]));
      check("branch_count",  int'(bus.branch_count),  int'(r[2*STAT_W-1:STAT_W]));
      check("mispred_count", int'(bus.mispred_count), int'(r[STAT_W-1:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] ops [4];
    logic [5:0] rop;
    n_cmp = 0;
    n_err = 0;
    ops[0] = 6'd5; ops[1] = 6'd6; ops[2] = 6'd7; ops[3] = 6'd1;
    model_reset();
    reset = 1'b1;
    bus.lookup_pc = 32'h40; bus.resolve_valid = 1'b0; bus.resolve_pc = 32'h0;
    bus.opcode = 6'd0; bus.igual = 1'b0; bus.maior = 1'b0; bus.menor = 1'b0;
    @(posedge clk);
    #1;

    // Reset state seen through lookup 0x40.
    idle(32'h40);

    // Taken BEQ at 0x40 from weak-NT: mispredict, entry becomes weak-T.
    resolve(32'h40, 32'h40, 6'd4, 1'b1, 1'b0, 1'b0);
    idle(32'h40);

    // Each remaining branch opcode against one-hot flags, then a non-branch.
    foreach (ops[k]) begin
      resolve(32'h100, 32'h100, ops[k], 1'b1, 1'b0, 1'b0);
      resolve(32'h100, 32'h100, ops[k], 1'b0, 1'b1, 1'b0);
      resolve(32'h100, 32'h100, ops[k], 1'b0, 1'b0, 1'b1);
    end
    resolve(32'h100, 32'h100, 6'h23, 1'b1, 1'b1, 1'b1);
    idle(32'h100);

    // Four taken BGT then one not-taken at 0x8, from clean counts.
    drive(1'b1, 32'h8, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) resolve(32'h8, 32'h8, 6'd7, 1'b0, 1'b1, 1'b0);
    resolve(32'h8, 32'h8, 6'd7, 1'b0, 1'b0, 1'b0);
    idle(32'h8);

    // Aliasing 0x4/0x44, and same-cycle lookup/update of index 1.
    drive(1'b1, 32'h44, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0);
    resolve(32'h44, 32'h4, 6'd4, 1'b1, 1'b0, 1'b0);
    resolve(32'h44, 32'h4, 6'd4, 1'b1, 1'b0, 1'b0);
    idle(32'h44);

    // Nine alternating outcomes all mispredict: counts saturate.
    drive(1'b1, 32'hC, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 9; n++)
      resolve(32'hC, 32'hC, 6'd4, (n % 2 == 0), 1'b0, 1'b0);
    idle(32'hC);

    // Reset on the same cycle as a valid resolve discards it.
    drive(1'b1, 32'hC, 1'b1, 32'hC, 6'd4, 1'b1, 1'b0, 1'b0);
    idle(32'hC);

    // Random traffic over a small PC range to force aliasing.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       rop = 6'h23;
        1:       rop = 6'($urandom_range(0, 63));
        default: rop = ops[$urandom_range(0, 3)];
      endcase
      if ($urandom_range(0, 2) == 0) rop = 6'd4;
      drive(($urandom_range(0, 59) == 0),
            32'($urandom_range(0, 47)) << 2,
            ($urandom_range(0, 3) != 0),
            32'($urandom_range(0, 47)) << 2,
            rop, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(32'h0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
